// File: rtl/token_window_buf_pkg.sv
// Shared constants and helpers for the token window buffer.
package token_window_pkg;

   localparam logic MODE_SLIDING = 1'b0;
   localparam logic MODE_BLOCK   = 1'b1;

   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/token_window_buf_if.sv
// Token-in / window-out handshake bundle for token_window_buf.
interface token_window_buf_if #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8
);
   import token_window_pkg::*;

   localparam int CNT_W = clog2(DEPTH + 1);

   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_W-1:0]       in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [DEPTH*DATA_W-1:0] out_data;
   logic [CNT_W-1:0]        out_count;
   logic                    out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_count, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_last
   );

endinterface

// File: rtl/token_window_buf_shift_reg.sv
// Token shift register: newest token enters at the MSB slice; clear and shift
// may coincide, yielding a register holding only the new token.
module twb_shift_reg #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic                    shift_i,
   input  logic [DATA_W-1:0]       data_i,
   output logic [DEPTH*DATA_W-1:0] sr_o
);

   localparam int SR_W = DEPTH * DATA_W;

   logic [SR_W-1:0] sr_q;
   logic [SR_W-1:0] sr_d;
   logic [SR_W-1:0] base;

   always_comb begin
      base = clr_i ? '0 : sr_q;
      sr_d = base;
      if (shift_i) begin
         sr_d = {data_i, base[SR_W-1:DATA_W]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign sr_o = sr_q;

endmodule

// File: rtl/token_window_buf.sv
// Serial-to-parallel token window buffer (sliding or block windows, flush with zero pad).
// Optional TOKEN_WINDOW_BUF_STATS_EN adds win_total / flush_total counters.
module token_window_buf
   import token_window_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic               flush,
   token_window_buf_if.slave  bus
`ifdef TOKEN_WINDOW_BUF_STATS_EN
   ,
   output logic [15:0]        win_total,
   output logic [15:0]        flush_total
`endif
);

   localparam int CNT_W = clog2(DEPTH + 1);
   localparam int SR_W  = DEPTH * DATA_W;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             mode_q, mode_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             in_ready;
   logic             accept, hs, flush_eff, complete, sr_clr;
   logic [SR_W-1:0]  sr;

   assign in_ready  = !out_valid_q || bus.out_ready;
   assign accept    = bus.in_valid && in_ready;
   assign hs        = out_valid_q && bus.out_ready;
   assign flush_eff = flush && !out_valid_q;

   always_comb begin
      sr_clr   = 1'b0;
      cnt_base = cnt_q;
      // A consumed block or flushed window restarts from empty; sliding keeps its history.
      if (hs && (mode_q == MODE_BLOCK || out_last_q)) begin
         cnt_base = '0;
         sr_clr   = 1'b1;
      end

      complete = 1'b0;
      if (accept) begin
         if (mode_q == MODE_BLOCK) complete = (cnt_base == DEPTH_M1);
         else                      complete = (cnt_base >= DEPTH_M1);
      end

      cnt_d = cnt_base;
      if (accept && cnt_base != DEPTH_C) begin
         cnt_d = cnt_base + CNT_W'(1);
      end

      out_valid_d = out_valid_q && !hs;
      out_last_d  = out_last_q;
      out_count_d = out_count_q;
      if (hs) begin
         out_last_d  = 1'b0;
         out_count_d = '0;
      end

      if (complete) begin
         out_valid_d = 1'b1;
         out_count_d = DEPTH_C;
         out_last_d  = flush_eff;
      end else if (flush_eff) begin
         // A full sliding window was already emitted, so flushing just empties it.
         if (cnt_d == DEPTH_C) begin
            cnt_d  = '0;
            sr_clr = 1'b1;
         end else if (cnt_d != '0) begin
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_count_d = cnt_d;
         end
      end

      mode_d = (cnt_q == '0 && !out_valid_q) ? mode : mode_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         mode_q      <= MODE_SLIDING;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_count_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_count_q <= out_count_d;
      end
   end

   twb_shift_reg #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_sr (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (sr_clr),
      .shift_i (accept),
      .data_i  (bus.in_data),
      .sr_o    (sr)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = sr;
   assign bus.out_count = out_count_q;
   assign bus.out_last  = out_last_q;

`ifdef TOKEN_WINDOW_BUF_STATS_EN
   logic [15:0] win_total_q, win_total_d;
   logic [15:0] flush_total_q, flush_total_d;

   always_comb begin
      win_total_d   = win_total_q;
      flush_total_d = flush_total_q;
      if (hs) begin
         win_total_d = win_total_q + 16'd1;
         if (out_last_q) flush_total_d = flush_total_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_total_q   <= '0;
         flush_total_q <= '0;
      end else begin
         win_total_q   <= win_total_d;
         flush_total_q <= flush_total_d;
      end
   end

   assign win_total   = win_total_q;
   assign flush_total = flush_total_q;
`endif

endmodule

// File: tb/tb_token_window_buf.sv
// Directed bench for token_window_buf (DATA_W=10, DEPTH=8).
module tb_token_window_buf;

   localparam int DATA_W = 10;
   localparam int DEPTH  = 8;

   logic clk;
   logic rst;
   logic mode;
   logic flush;
   int   n_cmp;
   int   n_err;
   logic [DEPTH*DATA_W-1:0] held;
`ifdef TOKEN_WINDOW_BUF_STATS_EN
   logic [15:0] win_total;
   logic [15:0] flush_total;
`endif

   token_window_buf_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   token_window_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .mode  (mode),
      .flush (flush),
      .bus   (bus)
`ifdef TOKEN_WINDOW_BUF_STATS_EN
      ,
      .win_total   (win_total),
      .flush_total (flush_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] tok);
      bus.in_valid = 1'b1;
      bus.in_data  = tok;
      step();
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [DATA_W-1:0] sl(input int i);
      logic [DEPTH*DATA_W-1:0] w;
      w = bus.out_data;
      return w[i*DATA_W +: DATA_W];
   endfunction

   // Window of consecutive tokens first..first+7, oldest in slice 0.
   function automatic logic [DEPTH*DATA_W-1:0] run_win(input int first);
      logic [DEPTH*DATA_W-1:0] w;
      w = '0;
      for (int i = 0; i < DEPTH; i++) w[i*DATA_W +: DATA_W] = DATA_W'(first + i);
      return w;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      mode = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      check("rst_out_valid", 80'(bus.out_valid), 80'(0));
      check("rst_out_count", 80'(bus.out_count), 80'(0));
      check("rst_out_last", 80'(bus.out_last), 80'(0));
      check("rst_out_data", 80'(bus.out_data), 80'(0));
      rst = 1'b1;
      step();
      check("rst_in_ready", 80'(bus.in_ready), 80'(1));

      // Block fill 1..8
      for (int t = 1; t <= 7; t++) send(DATA_W'(t));
      check("blk_no_early_win", 80'(bus.out_valid), 80'(0));
      send(10'd8);
      check("blk_valid", 80'(bus.out_valid), 80'(1));
      check("blk_count", 80'(bus.out_count), 80'(8));
      check("blk_last", 80'(bus.out_last), 80'(0));
      check("blk_data", 80'(bus.out_data), 80'(run_win(1)));
      check("blk_slice0", 80'(sl(0)), 80'(1));
      check("blk_slice7", 80'(sl(7)), 80'(8));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("blk_hs_valid", 80'(bus.out_valid), 80'(0));
      check("blk_hs_data", 80'(bus.out_data), 80'(0));
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("blk_empty_flush", 80'(bus.out_valid), 80'(0));

      // Backpressure
      for (int t = 1; t <= 8; t++) send(DATA_W'(t));
      held = bus.out_data;
      check("bp_valid", 80'(bus.out_valid), 80'(1));
      bus.in_valid = 1'b1;
      bus.in_data = 10'd9;
      for (int c = 0; c < 5; c++) begin
         check("bp_in_ready", 80'(bus.in_ready), 80'(0));
         check("bp_data_stable", 80'(bus.out_data), 80'(run_win(1)));
         step();
      end
      check("bp_held", 80'(bus.out_data), 80'(held));
      bus.out_ready = 1'b1;
      #1;
      check("bp_in_ready_up", 80'(bus.in_ready), 80'(1));
      step();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      check("bp_hs_valid", 80'(bus.out_valid), 80'(0));
      check("bp_tok9_slice7", 80'(sl(7)), 80'(9));
      check("bp_tok9_data", 80'(bus.out_data), {10'd9, 70'd0});
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("bp_cnt1_valid", 80'(bus.out_valid), 80'(1));
      check("bp_cnt1_count", 80'(bus.out_count), 80'(1));
      check("bp_cnt1_last", 80'(bus.out_last), 80'(1));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("bp_flush_hs_data", 80'(bus.out_data), 80'(0));

      // Flush partial
      send(10'h3FF);
      send(10'h001);
      send(10'h002);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fp_valid", 80'(bus.out_valid), 80'(1));
      check("fp_count", 80'(bus.out_count), 80'(3));
      check("fp_last", 80'(bus.out_last), 80'(1));
      check("fp_data", 80'(bus.out_data), {10'h002, 10'h001, 10'h3FF, 50'd0});
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fp_pending_flush_ignored", 80'(bus.out_count), 80'(3));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("fp_hs_valid", 80'(bus.out_valid), 80'(0));
      check("fp_hs_data", 80'(bus.out_data), 80'(0));

      // Flush with completing accept
      for (int t = 0; t < 7; t++) send(DATA_W'(16 + t));
      check("fa_cnt7_idle", 80'(bus.out_valid), 80'(0));
      bus.in_valid = 1'b1;
      bus.in_data = 10'h055;
      flush = 1'b1;
      step();
      bus.in_valid = 1'b0;
      flush = 1'b0;
      check("fa_valid", 80'(bus.out_valid), 80'(1));
      check("fa_count", 80'(bus.out_count), 80'(8));
      check("fa_last", 80'(bus.out_last), 80'(1));
      check("fa_slice7", 80'(sl(7)), 80'(10'h055));
      check("fa_slice0", 80'(sl(0)), 80'(10'h010));
      bus.out_ready = 1'b1;
      step();
      check("fa_hs_data", 80'(bus.out_data), 80'(0));

      // Sliding 1..10 with out_ready held high
      mode = 1'b0;
      step();
      for (int t = 1; t <= 7; t++) send(DATA_W'(t));
      check("sl_no_early_win", 80'(bus.out_valid), 80'(0));
      for (int t = 8; t <= 10; t++) begin
         send(DATA_W'(t));
         check("sl_valid", 80'(bus.out_valid), 80'(1));
         check("sl_count", 80'(bus.out_count), 80'(8));
         check("sl_window", 80'(bus.out_data), 80'(run_win(t - 7)));
      end
      check("sl_w3_slice0", 80'(sl(0)), 80'(3));
      check("sl_w3_slice7", 80'(sl(7)), 80'(10));
      step();
      bus.out_ready = 1'b0;
      check("sl_drain_valid", 80'(bus.out_valid), 80'(0));
      check("sl_keeps_history", 80'(bus.out_data), 80'(run_win(3)));
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("sl_full_flush_no_emit", 80'(bus.out_valid), 80'(0));
      check("sl_full_flush_clear", 80'(bus.out_data), 80'(0));

      // Reset mid-window
      mode = 1'b1;
      step();
      for (int t = 1; t <= 5; t++) send(DATA_W'(t));
      rst = 1'b0;
      #1;
      check("mr_valid", 80'(bus.out_valid), 80'(0));
      check("mr_data", 80'(bus.out_data), 80'(0));
`ifdef TOKEN_WINDOW_BUF_STATS_EN
      check("mr_win_total", 80'(win_total), 80'(0));
      check("mr_flush_total", 80'(flush_total), 80'(0));
`endif
      step();
      rst = 1'b1;
      step();
      for (int t = 1; t <= 7; t++) send(DATA_W'(t));
      check("mr_cnt_restart", 80'(bus.out_valid), 80'(0));
      send(10'd8);
      check("mr_refill_valid", 80'(bus.out_valid), 80'(1));
      check("mr_refill_data", 80'(bus.out_data), 80'(run_win(1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
